// File: rtl/pwm_pulse_generator.sv
// Periodic pulse/PWM source: period PRESCALER+1 cycles, high for PULSE_WIDTH+1
// cycles starting at phase OFFSET, window wrapping across the period boundary.
module pwm_pulse_generator #(
    parameter int unsigned PRESCALER   = 0,
    parameter int unsigned PULSE_WIDTH = 0,
    parameter int unsigned OFFSET      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic pulse_out
);

    localparam int unsigned PERIOD = PRESCALER + 1;
    localparam int unsigned CW     = (PRESCALER > 0) ? $clog2(PERIOD) : 1;
    // Distance from OFFSET to the end of the period; keeps the phase math unsigned-safe.
    localparam int unsigned BASE   = PERIOD - OFFSET;

    if (PULSE_WIDTH > PRESCALER) begin : g_bad_pulse_width
        $error("pwm_pulse_generator: PULSE_WIDTH must be in 0..PRESCALER");
    end
    if (OFFSET > PRESCALER) begin : g_bad_offset
        $error("pwm_pulse_generator: OFFSET must be in 0..PRESCALER");
    end

    logic [CW-1:0] c;
    logic [31:0]   shifted;
    logic [31:0]   phase;
    logic          in_window;
    logic          at_end;

    // Relative phase (c - OFFSET) mod PERIOD, formed as c + PERIOD - OFFSET folded once.
    always_comb begin
        shifted   = 32'(c) + 32'(BASE);
        phase     = (shifted >= 32'(PERIOD)) ? shifted - 32'(PERIOD) : shifted;
        in_window = (phase <= 32'(PULSE_WIDTH));
        at_end    = (32'(c) == 32'(PRESCALER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            pulse_out <= 1'b0;
        end else if (ena) begin
            pulse_out <= in_window;
            c         <= at_end ? '0 : c + CW'(1);
        end else begin
            pulse_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_pulse_generator.sv
// Self-checking bench: several parameterisations share clk/rst/ena and are
// compared against directed patterns and an edge-count reference model.
module tb_pwm_pulse_generator;

    localparam int unsigned NI = 9;
    localparam int unsigned PS  [NI] = '{0, 3, 3, 3, 3, 5, 5, 5, 5};
    localparam int unsigned PWS [NI] = '{0, 0, 1, 2, 3, 1, 3, 2, 5};
    localparam int unsigned OFS [NI] = '{0, 0, 0, 0, 0, 2, 4, 0, 3};
    // Expected outputs after enabled edges 1..12 from reset, edge 1 in the MSB.
    localparam logic [11:0] PAT [NI] = '{
        12'b111111111111, 12'b100010001000, 12'b110011001100,
        12'b111011101110, 12'b111111111111, 12'b001100001100,
        12'b110011110011, 12'b111000111000, 12'b111111111111};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic [NI-1:0] po;

    int tests  = 0;
    int failed = 0;
    int k      = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pwm_pulse_generator #(
            .PRESCALER  (PS[g]),
            .PULSE_WIDTH(PWS[g]),
            .OFFSET     (OFS[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .pulse_out(po[g])
        );
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Output after the n-th enabled edge since reset shows phase (n-1) mod period.
    function automatic logic model(input int g, input int n);
        int per;
        int ph;
        int rel;
        per = int'(PS[g]) + 1;
        ph  = (n - 1) % per;
        rel = (ph + per - int'(OFS[g])) % per;
        return logic'(rel <= int'(PWS[g]));
    endfunction

    task automatic step(input logic r, input logic e);
        logic exp;
        @(negedge clk);
        rst = r;
        ena = e;
        @(posedge clk);
        if (r) k = 0;
        else if (e) k++;
        #1;
        for (int g = 0; g < int'(NI); g++) begin
            exp = (!r && e) ? model(g, k) : 1'b0;
            chk($sformatf("model g%0d k%0d r%0b e%0b", g, k, r, e), po[g], exp);
        end
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] gap_pat;
        logic [1:0]  gap_ena [12];

        // Reset held for 10 cycles: every output low.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // Free run of 12 enabled edges against the fixed patterns.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            for (int g = 0; g < int'(NI); g++) begin
                pat = PAT[g];
                chk($sformatf("pattern g%0d edge%0d", g, i + 1), po[g], pat[11 - i]);
            end
        end

        // Enable gap after edge 2: P5/PW2/OFF0 resumes at c=2 without restart.
        step(1'b1, 1'b0);
        gap_pat = 12'b110001000111;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < 2 || i > 4) ? 1'b1 : 1'b0);
            chk($sformatf("gap g7 step%0d", i + 1), po[7], gap_pat[11 - i]);
        end

        // Single-cycle reset mid-run on the 100% duty instance.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midrun reset g8", po[8], 1'b0);
        step(1'b0, 1'b1);
        chk("after reset g8", po[8], 1'b1);
        chk("after reset g6 restarts", po[6], 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("after reset g5 phase2", po[5], 1'b1);

        // Randomised rst/ena traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
